// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying valid, a control bundle and a payload.
// It supports stall, a single-bubble flush and a programmable multi-cycle bubble sequence.
module pipe_stage_reg #(
  parameter int CTRL_W      = 5,
  parameter int DATA_W      = 128,
  parameter int MAX_BUBBLES = 3,
  parameter bit CLR_DATA    = 1'b1,
  localparam int CNT_W      = $clog2(MAX_BUBBLES + 1)
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble_req,
  input  logic [CNT_W-1:0]  bubble_len,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic              bubble_busy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BUBBLES);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_len_sat;
  logic              w_in_seq;

  // Requests longer than the sequencer supports are clamped, never wrapped.
  assign w_len_sat = (bubble_len > MAX_CNT) ? MAX_CNT : bubble_len;
  assign w_in_seq  = (r_cnt != '0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLR_DATA) r_data <= '0;
      r_cnt   <= '0;
    end else if (stall) begin
      r_valid <= r_valid;
      r_ctrl  <= r_ctrl;
      r_data  <= r_data;
      r_cnt   <= r_cnt;
    end else if (w_in_seq) begin
      // A request arriving here, even on the last bubble, is dropped.
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLR_DATA) r_data <= '0;
      r_cnt   <= r_cnt - 1'b1;
    end else begin
      r_valid <= valid_in;
      r_ctrl  <= ctrl_in;
      r_data  <= data_in;
      if (bubble_req) r_cnt <= w_len_sat;
    end
  end

  assign valid_out   = r_valid;
  assign ctrl_out    = r_ctrl;
  assign data_out    = r_data;
  assign bubble_cnt  = r_cnt;
  assign bubble_busy = w_in_seq;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance a uses default parameters, instance b has MAX_BUBBLES=2
// and CLR_DATA=0; both share the same stimulus.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic         valid_in = 1'b0;
  logic [4:0]   ctrl_in = '0;
  logic [127:0] data_in = '0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         bubble_req = 1'b0;
  logic [1:0]   bubble_len = '0;

  logic         a_valid, b_valid, a_busy, b_busy;
  logic [4:0]   a_ctrl, b_ctrl;
  logic [127:0] a_data, b_data;
  logic [1:0]   a_cnt, b_cnt;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] D1 = {16{8'hA5}};
  localparam logic [127:0] D2 = {4{32'h0F0F_0002}};
  localparam logic [127:0] D3 = {4{32'h1111_0003}};
  localparam logic [127:0] D4 = {4{32'h2222_0004}};
  localparam logic [127:0] D5 = {4{32'h3333_0005}};
  localparam logic [127:0] D6 = {4{32'h4444_0006}};
  localparam logic [127:0] D7 = {4{32'h5555_0007}};
  localparam logic [127:0] D8 = {4{32'h6666_0008}};
  localparam logic [127:0] D9 = {4{32'h7777_0009}};
  localparam logic [127:0] DA = {4{32'h8888_000A}};
  localparam logic [127:0] DB = {4{32'h9999_000B}};
  localparam logic [127:0] DC = {4{32'hAAAA_000C}};

  always #5 clk = ~clk;

  pipe_stage_reg u_a (
    .clk(clk), .nReset(nReset), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(data_in), .stall(stall), .flush(flush), .bubble_req(bubble_req),
    .bubble_len(bubble_len), .valid_out(a_valid), .ctrl_out(a_ctrl),
    .data_out(a_data), .bubble_busy(a_busy), .bubble_cnt(a_cnt)
  );

  pipe_stage_reg #(.MAX_BUBBLES(2), .CLR_DATA(1'b0)) u_b (
    .clk(clk), .nReset(nReset), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(data_in), .stall(stall), .flush(flush), .bubble_req(bubble_req),
    .bubble_len(bubble_len), .valid_out(b_valid), .ctrl_out(b_ctrl),
    .data_out(b_data), .bubble_busy(b_busy), .bubble_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic [127:0] d,
                       input logic st, input logic fl, input logic br, input logic [1:0] bl);
    valid_in = v; ctrl_in = c; data_in = d;
    stall = st; flush = fl; bubble_req = br; bubble_len = bl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [4:0] c,
                       input logic [127:0] d, input logic [1:0] n);
    chk({tag, ".a_valid"}, 128'(a_valid), 128'(v));
    chk({tag, ".a_ctrl"},  128'(a_ctrl),  128'(c));
    chk({tag, ".a_data"},  a_data, d);
    chk({tag, ".a_cnt"},   128'(a_cnt),   128'(n));
    chk({tag, ".a_busy"},  128'(a_busy),  128'(n != 2'd0));
  endtask

  initial begin
    // Reset state
    #2;
    chk_a("reset", 1'b0, 5'h00, '0, 2'd0);
    chk("reset.b_cnt", 128'(b_cnt), 128'd0);
    @(negedge clk);
    nReset = 1'b1;

    // Plain transfer, one-cycle latency
    drive(1'b1, 5'h1B, D1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("xfer", 1'b1, 5'h1B, D1, 2'd0);

    // Start a sequence, then reset asynchronously mid-sequence
    drive(1'b1, 5'h1C, D2, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    chk_a("seq_pre_rst", 1'b1, 5'h1C, D2, 2'd2);
    #2;
    nReset = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 5'h00, '0, 2'd0);
    chk("async_rst.b_data", b_data, '0);
    @(negedge clk);
    nReset = 1'b1;

    // Two-bubble sequence
    drive(1'b1, 5'h0F, D2, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    chk_a("seq2.c1", 1'b1, 5'h0F, D2, 2'd2);
    drive(1'b1, 5'h11, D3, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("seq2.c2", 1'b0, 5'h00, '0, 2'd1);
    chk("seq2.c2.b_data_hold", b_data, D2);
    tick();
    chk_a("seq2.c3", 1'b0, 5'h00, '0, 2'd0);
    tick();
    chk_a("seq2.c4", 1'b1, 5'h11, D3, 2'd0);

    // Stall freezes the sequence after the first bubble
    drive(1'b1, 5'h03, D4, 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    chk_a("stall.start", 1'b1, 5'h03, D4, 2'd3);
    drive(1'b1, 5'h04, D5, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("stall.b1", 1'b0, 5'h00, '0, 2'd2);
    drive(1'b1, 5'h04, D5, 1'b1, 1'b0, 1'b1, 2'd1);
    tick();
    chk_a("stall.h1", 1'b0, 5'h00, '0, 2'd2);
    tick();
    chk_a("stall.h2", 1'b0, 5'h00, '0, 2'd2);
    drive(1'b1, 5'h04, D5, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("stall.b2", 1'b0, 5'h00, '0, 2'd1);
    tick();
    chk_a("stall.b3", 1'b0, 5'h00, '0, 2'd0);
    tick();
    chk_a("stall.xfer", 1'b1, 5'h04, D5, 2'd0);
    drive(1'b1, 5'h05, D6, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("stall.hold_xfer", 1'b1, 5'h04, D5, 2'd0);

    // Clamping, request while busy, request on the final bubble
    drive(1'b1, 5'h06, D7, 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    chk_a("clamp.start", 1'b1, 5'h06, D7, 2'd3);
    chk("clamp.b_cnt", 128'(b_cnt), 128'd2);
    tick();
    chk_a("clamp.b1", 1'b0, 5'h00, '0, 2'd2);
    chk("busy_req.b_cnt", 128'(b_cnt), 128'd1);
    tick();
    chk_a("clamp.b2", 1'b0, 5'h00, '0, 2'd1);
    chk("last_req.b_cnt", 128'(b_cnt), 128'd0);
    chk("last_req.b_valid", 128'(b_valid), 128'd0);
    tick();
    chk_a("clamp.b3", 1'b0, 5'h00, '0, 2'd0);
    chk("after_last.b_valid", 128'(b_valid), 128'd1);
    chk("after_last.b_cnt", 128'(b_cnt), 128'd2);
    drive(1'b1, 5'h06, D7, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("clamp.end", 1'b1, 5'h06, D7, 2'd0);
    chk("after_last.b_bub", 128'(b_valid), 128'd0);
    tick();
    chk("after_last.b_cnt0", 128'(b_cnt), 128'd0);

    // Zero-length request behaves as a plain transfer
    drive(1'b1, 5'h07, D8, 1'b0, 1'b0, 1'b1, 2'd0);
    tick();
    chk_a("len0.c1", 1'b1, 5'h07, D8, 2'd0);
    drive(1'b1, 5'h08, D8, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("len0.c2", 1'b1, 5'h08, D8, 2'd0);

    // Flush + stall during a sequence
    drive(1'b1, 5'h08, D9, 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    chk_a("flush.start", 1'b1, 5'h08, D9, 2'd3);
    drive(1'b1, 5'h09, DA, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("flush.b1", 1'b0, 5'h00, '0, 2'd2);
    drive(1'b1, 5'h09, DA, 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    chk_a("flush.fs", 1'b0, 5'h00, '0, 2'd0);
    chk("flush.b_data_hold", b_data, D9);
    chk("flush.b_cnt", 128'(b_cnt), 128'd0);
    drive(1'b1, 5'h0A, DB, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("flush.resume", 1'b1, 5'h0A, DB, 2'd0);

    // Flush ignores a simultaneous bubble request
    drive(1'b1, 5'h0B, DC, 1'b0, 1'b1, 1'b1, 2'd2);
    tick();
    chk_a("flush_req", 1'b0, 5'h00, '0, 2'd0);
    chk("flush_req.b_data", b_data, DB);
    drive(1'b1, 5'h0B, DC, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    chk_a("flush_req.next", 1'b1, 5'h0B, DC, 2'd0);
    chk("flush_req.b_data_next", b_data, DC);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
